sync_fifo_prog: RTL

Single-clock FIFO with parametrised data width and depth, runtime-programmable almost-full and almost-empty thresholds, a fill-level output, and sticky overflow/underflow error flags. It is the same-clock counterpart of the team's dual-clock FIFO, with the same port vocabulary and flag semantics. It is used wherever producer and consumer share one clock, and replaces hand-built skid buffers and level counters.

---
 rtl/sync_fifo_prog.sv | 80 ++++++++
 1 files changed

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds, level output and sticky errors.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read data; default is registered read data.
module sync_fifo_prog #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          w_en,
   input  logic [DW-1:0] i_dat,
   output logic          w_full,
   output logic          w_almost_full,
   input  logic          r_en,
   output logic [DW-1:0] o_dat,
   output logic          r_empty,
   output logic          r_almost_empty,
   input  logic [AW:0]   i_af_thresh,
   input  logic [AW:0]   i_ae_thresh,
   output logic [AW:0]   o_level,
   input  logic          i_err_clr,
   output logic          o_overflow,
   output logic          o_underflow
);

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};
   localparam logic [AW:0] ONE   = {{AW{1'b0}}, 1'b1};

   logic [DW-1:0] mem [0:(1<<AW)-1];
   logic [AW:0]   wptr, rptr;
   logic [AW:0]   wptr_nxt, rptr_nxt, level_nxt;
   logic          wr_acc, rd_acc;

   // Flags are registered from the post-edge level, so requests never reach them combinationally.
   always_comb begin
      wr_acc    = w_en && !w_full && !rst;
      rd_acc    = r_en && !r_empty && !rst;
      wptr_nxt  = wr_acc ? wptr + ONE : wptr;
      rptr_nxt  = rd_acc ? rptr + ONE : rptr;
      level_nxt = wptr_nxt - rptr_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr           <= '0;
         rptr           <= '0;
         o_level        <= '0;
         w_full         <= 1'b0;
         w_almost_full  <= 1'b0;
         r_empty        <= 1'b1;
         r_almost_empty <= 1'b1;
         o_overflow     <= 1'b0;
         o_underflow    <= 1'b0;
      end else begin
         wptr           <= wptr_nxt;
         rptr           <= rptr_nxt;
         o_level        <= level_nxt;
         w_full         <= (level_nxt == DEPTH);
         w_almost_full  <= (level_nxt >= i_af_thresh);
         r_empty        <= (level_nxt == '0);
         r_almost_empty <= (level_nxt <= i_ae_thresh);
         // A new error event takes priority over a clear in the same cycle.
         o_overflow     <= (w_en && w_full) || (o_overflow && !i_err_clr);
         o_underflow    <= (r_en && r_empty) || (o_underflow && !i_err_clr);
      end
   end

   always_ff @(posedge clk) begin
      if (wr_acc) mem[wptr[AW-1:0]] <= i_dat;
   end

`ifdef SYNC_FIFO_FWFT_EN
   assign o_dat = mem[rptr[AW-1:0]];
`else
   always_ff @(posedge clk) begin
      if (rst)         o_dat <= '0;
      else if (rd_acc) o_dat <= mem[rptr[AW-1:0]];
   end
`endif

endmodule
